mem_req_arb: RTL and testbench

MEM_REQ_ARB -- requirements
Module: mem_req_arb

---
 rtl/mem_req_arb.sv | 133 +++++++++++++
 tb/tb_mem_req_arb.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_arb.sv
// Round-robin arbiter that funnels NUM_CH cache-line requesters onto one
// downstream memory port, keeping at most one transaction outstanding.
module mem_req_arb #(
    parameter int NUM_CH     = 3,
    parameter int ADDR_WIDTH = 64,
    parameter int LINE_WIDTH = 512
) (
    input  logic                                         clk,
    input  logic                                         reset_n,
    input  logic [NUM_CH-1:0]                            C_VALID,
    input  logic [NUM_CH-1:0]                            C_WRITE,
    input  logic [NUM_CH*ADDR_WIDTH-1:0]                 C_ADDR,
    input  logic [NUM_CH*LINE_WIDTH-1:0]                 C_WDATA,
    output logic [NUM_CH-1:0]                            C_READY,
    output logic [NUM_CH-1:0]                            C_DONE,
    output logic [NUM_CH*LINE_WIDTH-1:0]                 C_RDATA,
    output logic                                         M_REQ_VALID,
    input  logic                                         M_REQ_READY,
    output logic                                         M_REQ_WRITE,
    output logic [ADDR_WIDTH-1:0]                        M_REQ_ADDR,
    output logic [LINE_WIDTH-1:0]                        M_REQ_WDATA,
    input  logic                                         M_RESP_VALID,
    input  logic [LINE_WIDTH-1:0]                        M_RESP_DATA,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] GRANT_ID,
    output logic [31:0]                                  TXN_COUNT
);

    localparam int GW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int OFFS = $clog2(LINE_WIDTH / 8);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = {ADDR_WIDTH{1'b1}} << OFFS;
    localparam logic [GW-1:0] LAST_CH = GW'(NUM_CH - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t                       state_q;
    logic [GW-1:0]                rr_ptr_q;
    logic [GW-1:0]                grant_q;
    logic [NUM_CH-1:0]            ready_q;
    logic [NUM_CH-1:0]            done_q;
    logic [NUM_CH*LINE_WIDTH-1:0] rdata_q;
    logic                         req_valid_q;
    logic                         req_write_q;
    logic [ADDR_WIDTH-1:0]        req_addr_q;
    logic [LINE_WIDTH-1:0]        req_wdata_q;
    logic [31:0]                  txn_count_q;

    logic          found;
    logic [GW-1:0] pick;

    // Two passes give the wrap-around search: channels at or above rr_ptr first,
    // then the ones below it.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!found && C_VALID[i] && (i >= int'(rr_ptr_q))) begin
                found = 1'b1;
                pick  = GW'(i);
            end
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (!found && C_VALID[i] && (i < int'(rr_ptr_q))) begin
                found = 1'b1;
                pick  = GW'(i);
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments only, so every branch
    // below reads the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            ready_q     <= '0;
            done_q      <= '0;
            // NOTE: the read-line registers are reset because requesters observe
            // them directly and must see zero, not power-up garbage.
            rdata_q     <= '0;
            req_valid_q <= 1'b0;
            req_write_q <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            txn_count_q <= '0;
        end else begin
            ready_q <= '0;
            done_q  <= '0;
            case (state_q)
                IDLE: begin
                    if (found) begin
                        grant_q       <= pick;
                        ready_q[pick] <= 1'b1;
                        req_valid_q   <= 1'b1;
                        req_write_q   <= C_WRITE[pick];
                        req_addr_q    <= C_ADDR[int'(pick)*ADDR_WIDTH +: ADDR_WIDTH] & ADDR_MASK;
                        req_wdata_q   <= C_WDATA[int'(pick)*LINE_WIDTH +: LINE_WIDTH];
                        state_q       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (M_REQ_READY) begin
                        req_valid_q <= 1'b0;
                        state_q     <= WAIT;
                    end
                end
                WAIT: begin
                    if (M_RESP_VALID) begin
                        done_q[grant_q] <= 1'b1;
                        if (!req_write_q) begin
                            rdata_q[int'(grant_q)*LINE_WIDTH +: LINE_WIDTH] <= M_RESP_DATA;
                        end
                        rr_ptr_q    <= (grant_q == LAST_CH) ? '0 : grant_q + GW'(1);
                        txn_count_q <= txn_count_q + 32'd1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign C_READY     = ready_q;
    assign C_DONE      = done_q;
    assign C_RDATA     = rdata_q;
    assign M_REQ_VALID = req_valid_q;
    assign M_REQ_WRITE = req_write_q;
    assign M_REQ_ADDR  = req_addr_q;
    assign M_REQ_WDATA = req_wdata_q;
    assign GRANT_ID    = grant_q;
    assign TXN_COUNT   = txn_count_q;

endmodule

// File: tb/tb_mem_req_arb.sv
// Directed bench for mem_req_arb: a per-cycle vector table for reset, a single
// read and round-robin, then hand sequences for write/read, backpressure, reset and wrap.
module tb_mem_req_arb;

    logic           clk;
    logic           reset_n;
    logic [2:0]     c_valid;
    logic [2:0]     c_write;
    logic [191:0]   c_addr;
    logic [1535:0]  c_wdata;
    logic [2:0]     c_ready;
    logic [2:0]     c_done;
    logic [1535:0]  c_rdata;
    logic           m_req_valid;
    logic           m_req_ready;
    logic           m_req_write;
    logic [63:0]    m_req_addr;
    logic [511:0]   m_req_wdata;
    logic           m_resp_valid;
    logic [511:0]   m_resp_data;
    logic [1:0]     grant_id;
    logic [31:0]    txn_count;

    int n_checks = 0;
    int n_errors = 0;

    mem_req_arb dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .C_VALID      (c_valid),
        .C_WRITE      (c_write),
        .C_ADDR       (c_addr),
        .C_WDATA      (c_wdata),
        .C_READY      (c_ready),
        .C_DONE       (c_done),
        .C_RDATA      (c_rdata),
        .M_REQ_VALID  (m_req_valid),
        .M_REQ_READY  (m_req_ready),
        .M_REQ_WRITE  (m_req_write),
        .M_REQ_ADDR   (m_req_addr),
        .M_REQ_WDATA  (m_req_wdata),
        .M_RESP_VALID (m_resp_valid),
        .M_RESP_DATA  (m_resp_data),
        .GRANT_ID     (grant_id),
        .TXN_COUNT    (txn_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst_n;
        logic [2:0]  valid;
        logic        mready;
        logic        resp;
        logic [31:0] rdat;
        logic [2:0]  e_ready;
        logic [2:0]  e_done;
        logic        e_mvalid;
        logic [1:0]  e_gid;
        logic [31:0] e_cnt;
        logic [63:0] e_addr;
        logic [31:0] e_rd0;
        logic [31:0] e_rd1;
        logic [31:0] e_rd2;
    } vec_t;

    vec_t tbl[20];

    function automatic vec_t mk(string n, logic r, logic [2:0] v, logic mr, logic rp,
                                logic [31:0] d, logic [2:0] er, logic [2:0] ed, logic em,
                                logic [1:0] eg, logic [31:0] ec, logic [63:0] ea,
                                logic [31:0] e0, logic [31:0] e1, logic [31:0] e2);
        vec_t t;
        t.name = n; t.rst_n = r; t.valid = v; t.mready = mr; t.resp = rp; t.rdat = d;
        t.e_ready = er; t.e_done = ed; t.e_mvalid = em; t.e_gid = eg; t.e_cnt = ec;
        t.e_addr = ea; t.e_rd0 = e0; t.e_rd1 = e1; t.e_rd2 = e2;
        return t;
    endfunction

    task automatic check(string name, logic [511:0] act, logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [511:0] rd(int ch);
        return c_rdata[ch*512 +: 512];
    endfunction

    // Outputs are sampled 1 time unit after the rising edge they result from.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n      = 1'b0;
        c_valid      = '0;
        c_write      = '0;
        c_addr       = {64'h30FF, 64'h2000, 64'h1047};
        c_wdata      = '0;
        c_wdata[0*512 +: 512] = 512'hA0;
        c_wdata[1*512 +: 512] = 512'hB1;
        c_wdata[2*512 +: 512] = 512'hC2C2;
        m_req_ready  = 1'b1;
        m_resp_valid = 1'b0;
        m_resp_data  = '0;

        //             name          rst v       mr rp data   ready   done    mv gid cnt addr      rd0    rd1  rd2
        tbl[0]  = mk("reset",        0, 3'b000, 1, 0, 0,      3'b000, 3'b000, 0, 0, 0, 64'h0,    0,     0,   0);
        tbl[1]  = mk("rd_grant",     1, 3'b001, 1, 0, 0,      3'b001, 3'b000, 1, 0, 0, 64'h1040, 0,     0,   0);
        tbl[2]  = mk("rd_issue",     1, 3'b000, 1, 0, 0,      3'b000, 3'b000, 0, 0, 0, 64'h1040, 0,     0,   0);
        tbl[3]  = mk("rd_wait",      1, 3'b000, 1, 0, 0,      3'b000, 3'b000, 0, 0, 0, 64'h1040, 0,     0,   0);
        tbl[4]  = mk("rd_resp",      1, 3'b000, 1, 1, 'hABCD, 3'b000, 3'b001, 0, 0, 1, 64'h1040, 'hABCD, 0,  0);
        tbl[5]  = mk("rd_idle",      1, 3'b000, 1, 0, 0,      3'b000, 3'b000, 0, 0, 1, 64'h1040, 'hABCD, 0,  0);
        tbl[6]  = mk("reset2",       0, 3'b000, 1, 0, 0,      3'b000, 3'b000, 0, 0, 0, 64'h0,    0,     0,   0);
        tbl[7]  = mk("rr0_grant",    1, 3'b111, 1, 0, 0,      3'b001, 3'b000, 1, 0, 0, 64'h1040, 0,     0,   0);
        tbl[8]  = mk("rr0_issue",    1, 3'b111, 1, 0, 0,      3'b000, 3'b000, 0, 0, 0, 64'h1040, 0,     0,   0);
        tbl[9]  = mk("rr0_resp",     1, 3'b111, 1, 1, 'h11,   3'b000, 3'b001, 0, 0, 1, 64'h1040, 'h11,  0,   0);
        tbl[10] = mk("rr1_grant",    1, 3'b111, 1, 0, 0,      3'b010, 3'b000, 1, 1, 1, 64'h2000, 'h11,  0,   0);
        tbl[11] = mk("rr1_spur_iss", 1, 3'b111, 1, 1, 'h55,   3'b000, 3'b000, 0, 1, 1, 64'h2000, 'h11,  0,   0);
        tbl[12] = mk("rr1_resp",     1, 3'b111, 1, 1, 'h22,   3'b000, 3'b010, 0, 1, 2, 64'h2000, 'h11,  'h22, 0);
        tbl[13] = mk("rr2_grant",    1, 3'b111, 1, 0, 0,      3'b100, 3'b000, 1, 2, 2, 64'h30C0, 'h11,  'h22, 0);
        tbl[14] = mk("rr2_issue",    1, 3'b111, 1, 0, 0,      3'b000, 3'b000, 0, 2, 2, 64'h30C0, 'h11,  'h22, 0);
        tbl[15] = mk("rr2_resp",     1, 3'b111, 1, 1, 'h33,   3'b000, 3'b100, 0, 2, 3, 64'h30C0, 'h11,  'h22, 'h33);
        tbl[16] = mk("rr3_grant",    1, 3'b111, 1, 0, 0,      3'b001, 3'b000, 1, 0, 3, 64'h1040, 'h11,  'h22, 'h33);
        tbl[17] = mk("rr3_issue",    1, 3'b111, 1, 0, 0,      3'b000, 3'b000, 0, 0, 3, 64'h1040, 'h11,  'h22, 'h33);
        tbl[18] = mk("rr3_resp",     1, 3'b111, 1, 1, 'h44,   3'b000, 3'b001, 0, 0, 4, 64'h1040, 'h44,  'h22, 'h33);
        tbl[19] = mk("idle_spur",    1, 3'b000, 1, 1, 'h99,   3'b000, 3'b000, 0, 0, 4, 64'h1040, 'h44,  'h22, 'h33);

        for (int i = 0; i < 20; i++) begin
            reset_n      = tbl[i].rst_n;
            c_valid      = tbl[i].valid;
            m_req_ready  = tbl[i].mready;
            m_resp_valid = tbl[i].resp;
            m_resp_data  = 512'(tbl[i].rdat);
            step();
            check({tbl[i].name, ".ready"}, 512'(c_ready),     512'(tbl[i].e_ready));
            check({tbl[i].name, ".done"},  512'(c_done),      512'(tbl[i].e_done));
            check({tbl[i].name, ".mvalid"},512'(m_req_valid), 512'(tbl[i].e_mvalid));
            check({tbl[i].name, ".gid"},   512'(grant_id),    512'(tbl[i].e_gid));
            check({tbl[i].name, ".cnt"},   512'(txn_count),   512'(tbl[i].e_cnt));
            check({tbl[i].name, ".addr"},  512'(m_req_addr),  512'(tbl[i].e_addr));
            check({tbl[i].name, ".rd0"},   rd(0),             512'(tbl[i].e_rd0));
            check({tbl[i].name, ".rd1"},   rd(1),             512'(tbl[i].e_rd1));
            check({tbl[i].name, ".rd2"},   rd(2),             512'(tbl[i].e_rd2));
        end
        m_resp_valid = 1'b0;

        // Write then read on channel 1; rr_ptr is 1 here.
        c_valid = 3'b010; c_write = 3'b010;
        c_wdata[1*512 +: 512] = 512'hDEADBEEF;
        step();
        check("wr.ready", 512'(c_ready), 512'(3'b010));
        check("wr.mwrite", 512'(m_req_write), 512'(1'b1));
        check("wr.wdata", m_req_wdata, 512'hDEADBEEF);
        check("wr.addr", 512'(m_req_addr), 512'h2000);
        c_valid = 3'b000; c_write = 3'b000;
        step();
        check("wr.wait_mvalid", 512'(m_req_valid), 512'(1'b0));
        m_resp_valid = 1'b1; m_resp_data = 512'hFFFF;
        step();
        m_resp_valid = 1'b0;
        check("wr.done", 512'(c_done), 512'(3'b010));
        check("wr.rd1_unchanged", rd(1), 512'h22);
        check("wr.cnt", 512'(txn_count), 512'd5);
        c_valid = 3'b010;
        step();
        c_valid = 3'b000;
        check("rd1.ready", 512'(c_ready), 512'(3'b010));
        check("rd1.mwrite", 512'(m_req_write), 512'(1'b0));
        step();
        m_resp_valid = 1'b1; m_resp_data = 512'hDEADBEEF;
        step();
        m_resp_valid = 1'b0;
        check("rd1.done", 512'(c_done), 512'(3'b010));
        check("rd1.rdata", rd(1), 512'hDEADBEEF);
        check("rd1.rd0_other", rd(0), 512'h44);
        check("rd1.cnt", 512'(txn_count), 512'd6);

        // Backpressure on channel 2 with its inputs and other requesters changing.
        c_valid = 3'b100; m_req_ready = 1'b0;
        step();
        check("bp.ready", 512'(c_ready), 512'(3'b100));
        check("bp.gid", 512'(grant_id), 512'd2);
        c_addr[2*64 +: 64] = 64'hFFFF_0000;
        c_wdata[2*512 +: 512] = 512'h1234;
        c_write = 3'b100;
        c_valid = 3'b011;
        for (int k = 0; k < 5; k++) begin
            step();
            check($sformatf("bp.mvalid%0d", k), 512'(m_req_valid), 512'(1'b1));
            check($sformatf("bp.addr%0d", k),   512'(m_req_addr),  512'h30C0);
            check($sformatf("bp.mwrite%0d", k), 512'(m_req_write), 512'(1'b0));
            check($sformatf("bp.wdata%0d", k),  m_req_wdata,       512'hC2C2);
            check($sformatf("bp.noready%0d", k),512'(c_ready),     512'(3'b000));
        end
        c_valid = 3'b000; m_req_ready = 1'b1;
        step();
        check("bp.wait_mvalid", 512'(m_req_valid), 512'(1'b0));
        m_resp_valid = 1'b1; m_resp_data = 512'h77;
        step();
        m_resp_valid = 1'b0;
        check("bp.done", 512'(c_done), 512'(3'b100));
        check("bp.rd2", rd(2), 512'h77);
        c_addr[2*64 +: 64] = 64'h30FF; c_write = 3'b000;

        // Reset while in WAIT abandons the transaction.
        c_valid = 3'b001;
        step();
        c_valid = 3'b000;
        step();
        reset_n = 1'b0;
        step();
        check("rst.cnt", 512'(txn_count), 512'd0);
        check("rst.done", 512'(c_done), 512'(3'b000));
        check("rst.mvalid", 512'(m_req_valid), 512'(1'b0));
        check("rst.addr", 512'(m_req_addr), 512'd0);
        check("rst.wdata", m_req_wdata, 512'd0);
        check("rst.rdata", 512'(c_rdata[1535:1024] | c_rdata[1023:512] | c_rdata[511:0]), 512'd0);
        reset_n = 1'b1; m_resp_valid = 1'b1; m_resp_data = 512'hBAD;
        step();
        m_resp_valid = 1'b0;
        check("rst.late_resp_done", 512'(c_done), 512'(3'b000));
        check("rst.late_resp_cnt", 512'(txn_count), 512'd0);
        check("rst.late_resp_rd0", rd(0), 512'd0);
        c_valid = 3'b011;
        step();
        c_valid = 3'b000;
        check("rst.regrant", 512'(c_ready), 512'(3'b001));
        step();
        m_resp_valid = 1'b1; m_resp_data = 512'h5A;
        step();
        m_resp_valid = 1'b0;
        check("rst.txn_done", 512'(c_done), 512'(3'b001));
        check("rst.txn_cnt", 512'(txn_count), 512'd1);

        // Counter wrap from the all-ones value.
        force dut.txn_count_q = 32'hFFFF_FFFF;
        step();
        release dut.txn_count_q;
        step();
        check("wrap.pre", 512'(txn_count), 512'hFFFF_FFFF);
        c_valid = 3'b001;
        step();
        c_valid = 3'b000;
        step();
        m_resp_valid = 1'b1; m_resp_data = 512'h66;
        step();
        m_resp_valid = 1'b0;
        check("wrap.done", 512'(c_done), 512'(3'b001));
        check("wrap.cnt", 512'(txn_count), 512'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
